// File: rtl/axi3_read_slave_model.sv
// AXI3 read-channel slave model: queues AR requests and returns INCR bursts
// whose data is derived from the beat address, with programmable latency/gap.
module axi3_read_slave_model #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int AR_FIFO_DEPTH = 4,
  parameter int AR_LATENCY    = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  output logic                  s_axi_arready,
  input  logic                  s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [3:0]            s_axi_arlen,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic                  s_axi_rlast,
  output logic [15:0]           BURSTS_DONE,
  output logic                  PROTOCOL_ERR
);
  localparam int PW = $clog2(AR_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LAT  = 2'd1;
  localparam logic [1:0] BEAT = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [3:0] LAT_LOAD = 4'(AR_LATENCY);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
  localparam logic [CW-1:0] DEPTH = CW'(AR_FIFO_DEPTH);

  // Low word is the beat address; a 64-bit bus carries its inverse on top.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] a64;
    logic [63:0] d64;
    a64 = 64'(a);
    d64 = {~a64[31:0], a64[31:0]};
    return d64[DATA_WIDTH-1:0];
  endfunction

  logic [EW-1:0]         fifo_mem [AR_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r, count_n;
  logic                  arready_r;
  logic [1:0]            state_r, state_n;
  logic [3:0]            cnt_r, cnt_n, beat_r, beat_n, len_r, len_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic                  rvalid_r, rlast_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [15:0]           done_r;
  logic                  err_r, stall_r;
  logic [ADDR_WIDTH-1:0] prev_addr_r;
  logic [3:0]            prev_len_r;
  logic                  push_s, pop_s, done_s;
  logic [EW-1:0]         head_s;

  assign push_s = s_axi_arvalid & arready_r;
  assign head_s = fifo_mem[rd_ptr_r];

  // Burst sequencing: next state, counters and beat address.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    beat_n  = beat_r;
    len_n   = len_r;
    addr_n  = addr_r;
    pop_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != '0) begin
          pop_s  = 1'b1;
          addr_n = head_s[EW-1:4];
          len_n  = head_s[3:0];
          beat_n = 4'd0;
          if (LAT_LOAD == 4'd0) begin
            state_n = BEAT;
          end else begin
            state_n = LAT;
            cnt_n   = LAT_LOAD;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LAT, GAP: begin
        if (cnt_r <= 4'd1) begin
          state_n = BEAT;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      BEAT: begin
        if (s_axi_rready) begin
          if (beat_r == len_r) begin
            done_s  = 1'b1;
            state_n = IDLE;
          end else begin
            beat_n = beat_r + 4'd1;
            addr_n = addr_r + STEP;
            if (GAP_LOAD == 4'd0) begin
              state_n = BEAT;
            end else begin
              state_n = GAP;
              cnt_n   = GAP_LOAD;
            end
          end
        end else begin
          state_n = BEAT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_n = count_r + CW'(1);
      2'b01:   count_n = count_r - CW'(1);
      default: count_n = count_r;
    endcase
  end

  // Request storage has no reset; validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem[wr_ptr_r] <= {s_axi_araddr, s_axi_arlen};
    end
  end

  // FIFO pointers, occupancy and the registered arready.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      arready_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r   <= count_n;
      arready_r <= (count_n < DEPTH);
    end
  end

  // FSM state plus R outputs registered from the next-state view.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      beat_r   <= 4'd0;
      len_r    <= 4'd0;
      addr_r   <= '0;
      rvalid_r <= 1'b0;
      rlast_r  <= 1'b0;
      rdata_r  <= '0;
      done_r   <= 16'd0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      beat_r   <= beat_n;
      len_r    <= len_n;
      addr_r   <= addr_n;
      rvalid_r <= (state_n == BEAT);
      rlast_r  <= (state_n == BEAT) && (beat_n == len_n);
      rdata_r  <= (state_n == BEAT) ? beat_data(addr_n) : '0;
      if (done_s) done_r <= done_r + 16'd1;
    end
  end

  // A stalled AR must keep arvalid high and its payload stable.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_r     <= 1'b0;
      prev_addr_r <= '0;
      prev_len_r  <= 4'd0;
      err_r       <= 1'b0;
    end else begin
      stall_r     <= s_axi_arvalid & ~arready_r;
      prev_addr_r <= s_axi_araddr;
      prev_len_r  <= s_axi_arlen;
      if (stall_r && (!s_axi_arvalid || (s_axi_araddr != prev_addr_r) ||
                      (s_axi_arlen != prev_len_r))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rlast   = rlast_r;
  assign BURSTS_DONE   = done_r;
  assign PROTOCOL_ERR  = err_r;
endmodule

// File: tb/tb_axi3_read_slave_model.sv
// Bench for axi3_read_slave_model: directed scenarios plus random bursts,
// scored against a queue of expected beats built from each accepted AR.
module tb_axi3_read_slave_model;
  logic        clk, rst_n;
  logic        a_arready, a_arvalid, a_rvalid, a_rready, a_rlast, a_err;
  logic [31:0] a_araddr, a_rdata;
  logic [3:0]  a_arlen;
  logic [15:0] a_done;
  logic        b_arready, b_arvalid, b_rvalid, b_rready, b_rlast, b_err;
  logic [31:0] b_araddr;
  logic [63:0] b_rdata;
  logic [3:0]  b_arlen;
  logic [15:0] b_done;

  int checks = 0;
  int errors = 0;
  int model_done = 0;
  bit rand_mode = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];
  beat_t exp_b;
  bit          held_v = 0;
  logic [31:0] held_d;
  logic        held_l;

  axi3_read_slave_model u_a (
    .CLK(clk), .RESET_N(rst_n),
    .s_axi_arready(a_arready), .s_axi_arvalid(a_arvalid),
    .s_axi_araddr(a_araddr), .s_axi_arlen(a_arlen),
    .s_axi_rvalid(a_rvalid), .s_axi_rready(a_rready),
    .s_axi_rdata(a_rdata), .s_axi_rlast(a_rlast),
    .BURSTS_DONE(a_done), .PROTOCOL_ERR(a_err)
  );

  axi3_read_slave_model #(.DATA_WIDTH(64), .GAP_CYCLES(0)) u_b (
    .CLK(clk), .RESET_N(rst_n),
    .s_axi_arready(b_arready), .s_axi_arvalid(b_arvalid),
    .s_axi_araddr(b_araddr), .s_axi_arlen(b_arlen),
    .s_axi_rvalid(b_rvalid), .s_axi_rready(b_rready),
    .s_axi_rdata(b_rdata), .s_axi_rlast(b_rlast),
    .BURSTS_DONE(b_done), .PROTOCOL_ERR(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) a_rready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] len);
    int n = 0;
    a_arvalid = 1'b1;
    a_araddr  = addr;
    a_arlen   = len;
    while (!a_arready && n < 3000) begin
      tick();
      n++;
    end
    chk("ar_accept", 64'(n < 3000), 64'd1);
    tick();
    a_arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || a_rvalid) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask

  // Scoreboard on the falling edge: inputs and outputs are settled here.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_done = 0;
      held_v = 0;
    end else begin
      if (a_arvalid && a_arready) begin
        for (int k = 0; k <= int'(a_arlen); k++) begin
          exp_b.data = a_araddr + 32'(k * 4);
          exp_b.last = (k == int'(a_arlen));
          exp_q.push_back(exp_b);
        end
      end
      if (held_v) begin
        chk("hold_valid", 64'(a_rvalid), 64'd1);
        chk("hold_data", 64'(a_rdata), 64'(held_d));
        chk("hold_last", 64'(a_rlast), 64'(held_l));
      end
      if (!a_rvalid) begin
        chk("idle_data", 64'(a_rdata), 64'd0);
        chk("idle_last", 64'(a_rlast), 64'd0);
      end else if (a_rready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          exp_b = exp_q.pop_front();
          chk("beat_data", 64'(a_rdata), 64'(exp_b.data));
          chk("beat_last", 64'(a_rlast), 64'(exp_b.last));
          if (exp_b.last) model_done++;
        end
      end
      held_v = a_rvalid && !a_rready;
      held_d = a_rdata;
      held_l = a_rlast;
    end
  end

  initial begin
    int n;
    logic [31:0] lo;
    rst_n = 1'b0;
    a_arvalid = 1'b0; a_araddr = 32'd0; a_arlen = 4'd0; a_rready = 1'b1;
    b_arvalid = 1'b0; b_araddr = 32'd0; b_arlen = 4'd0; b_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 64'(a_arready), 64'd0);
    chk("rst_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_arready", 64'(a_arready), 64'd0);
    tick();
    chk("rel_arready_up", 64'(a_arready), 64'd1);

    // Single burst: latency 2, gap 1, beats on alternate cycles.
    send_ar(32'h8000_0000, 4'd15);
    tick(); chk("lat_t1", 64'(a_rvalid), 64'd0);
    tick(); chk("lat_t2", 64'(a_rvalid), 64'd0);
    tick(); chk("lat_t3", 64'(a_rvalid), 64'd1);
    chk("first_data", 64'(a_rdata), 64'h8000_0000);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("alt_valid", 64'(a_rvalid), 64'((i % 2) == 0));
    end
    tick();
    chk("burst1_done", 64'(a_done), 64'd1);

    // Back-pressure at beat 3.
    send_ar(32'h8000_0000, 4'd15);
    n = 0;
    while (!(a_rvalid && a_rdata == 32'h8000_000C) && n < 200) begin
      tick();
      n++;
    end
    chk("bp_reach", 64'(n < 200), 64'd1);
    a_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(a_rvalid), 64'd1);
      chk("bp_data", 64'(a_rdata), 64'h8000_000C);
    end
    a_rready = 1'b1;
    wait_drain("bp_drain");
    chk("burst2_done", 64'(a_done), 64'd2);

    // FIFO full: one burst stalled in the FSM, four queued, fifth refused.
    a_rready = 1'b0;
    send_ar(32'h0000_0000, 4'd0);
    tick(); tick();
    for (int i = 1; i <= 4; i++) send_ar(32'(i * 256), 4'd0);
    a_arvalid = 1'b1; a_araddr = 32'h500; a_arlen = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk("full_arready", 64'(a_arready), 64'd0);
      tick();
    end
    a_rready = 1'b1;
    send_ar(32'h500, 4'd0);
    wait_drain("full_drain");
    chk("full_done", 64'(a_done), 64'd8);
    chk("full_noerr", 64'(a_err), 64'd0);

    // Protocol error: stalled AR changes its address.
    a_rready = 1'b0;
    send_ar(32'h2000, 4'd0);
    tick(); tick();
    for (int i = 1; i <= 4; i++) send_ar(32'h2000 + 32'(i * 256), 4'd0);
    a_arvalid = 1'b1; a_araddr = 32'h2500; a_arlen = 4'd0;
    tick(); tick();
    chk("perr_stable", 64'(a_err), 64'd0);
    a_araddr = 32'h2504;
    tick();
    chk("perr_set", 64'(a_err), 64'd1);
    a_arvalid = 1'b0;
    a_rready = 1'b1;
    wait_drain("perr_drain");
    chk("perr_sticky", 64'(a_err), 64'd1);

    // 64-bit instance: address wrap, inverted high word, back-to-back beats.
    b_arvalid = 1'b1; b_araddr = 32'hFFFF_FFF0; b_arlen = 4'd3;
    n = 0;
    while (!b_arready && n < 50) begin tick(); n++; end
    tick();
    b_arvalid = 1'b0;
    n = 0;
    while (!b_rvalid && n < 50) begin tick(); n++; end
    chk("w_reach", 64'(n < 50), 64'd1);
    for (int k = 0; k < 4; k++) begin
      lo = 32'hFFFF_FFF0 + 32'(k * 8);
      chk("w_valid", 64'(b_rvalid), 64'd1);
      chk("w_data", b_rdata, {~lo, lo});
      chk("w_last", 64'(b_rlast), 64'(k == 3));
      tick();
    end
    chk("w_end", 64'(b_rvalid), 64'd0);
    chk("w_done", 64'(b_done), 64'd1);

    // Reset in the middle of beat 7.
    send_ar(32'h1000, 4'd15);
    n = 0;
    while (!(a_rvalid && a_rdata == 32'h101C) && n < 200) begin tick(); n++; end
    chk("mr_reach", 64'(n < 200), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_arready", 64'(a_arready), 64'd0);
    chk("mr_rvalid", 64'(a_rvalid), 64'd0);
    chk("mr_rlast", 64'(a_rlast), 64'd0);
    chk("mr_rdata", 64'(a_rdata), 64'd0);
    chk("mr_done", 64'(a_done), 64'd0);
    chk("mr_err", 64'(a_err), 64'd0);
    chk("mr_b_done", 64'(b_done), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mr_rel_arready", 64'(a_arready), 64'd1);
    for (int i = 0; i < 20; i++) begin
      chk("mr_no_beat", 64'(a_rvalid), 64'd0);
      tick();
    end
    chk("mr_done_zero", 64'(a_done), 64'd0);

    // Random bursts with random back-pressure.
    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_ar($urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_mode = 0;
    a_rready = 1'b1;
    wait_drain("rand_drain");
    chk("rand_done", 64'(a_done), 64'(16'(model_done)));
    chk("rand_noerr", 64'(a_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
